// File: rtl/quiz_judge_scoreboard.sv
// quiz_judge_scoreboard: judges one quiz round at a time. It latches the first
// lit group, runs a bounded answer window, and applies the host verdict or a
// timeout to a saturating per-group score. It then pulses a clear request back
// to the lamp logic and waits for all lamps to go dark before re-arming.
// All outputs come straight from registers.
module quiz_judge_scoreboard #(
  parameter int ANSWER_CYCLES = 50,
  parameter int CLR_CYCLES    = 2,
  parameter int SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         lamp,
  input  logic               correct,
  input  logic               wrong,
  input  logic               score_clr,
  output logic               clr_req,
  output logic               busy,
  output logic [1:0]         grp,
  output logic [7:0]         remaining,
  output logic               timeout,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2
);

  // The counter only has to reach CLR_CYCLES-1, but it needs at least one bit.
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [7:0] WINDOW = 8'(ANSWER_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ANSWER,
    S_CLEAR,
    S_WAIT_DARK
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [1:0]         r_grp;
  logic [1:0]         w_nextGrp;
  logic [7:0]         r_remaining;
  logic [7:0]         w_nextRemaining;
  logic               r_clrReq;
  logic               w_nextClrReq;
  logic               r_timeout;
  logic               w_nextTimeout;
  logic               r_busy;
  logic [CW-1:0]      r_clrCnt;
  logic [CW-1:0]      w_nextClrCnt;
  logic               w_scoreInc;
  logic [1:0]         w_lowestLamp;
  logic [SCORE_W-1:0] r_score0;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;

  // Lowest set lamp bit wins when several groups light in the same cycle.
  always_comb begin
    w_lowestLamp = 2'd2;
    if (lamp[0]) begin
      w_lowestLamp = 2'd0;
    end else if (lamp[1]) begin
      w_lowestLamp = 2'd1;
    end
  end

  // State register for the round sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and next-output logic; a verdict in ANSWER beats the timeout,
  // and wrong overrides correct when both are present.
  always_comb begin
    w_nextState     = r_state;
    w_nextGrp       = r_grp;
    w_nextRemaining = r_remaining;
    w_nextClrReq    = r_clrReq;
    w_nextTimeout   = 1'b0;
    w_nextClrCnt    = r_clrCnt;
    w_scoreInc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nextClrReq = 1'b0;
        if (lamp != 3'b000) begin
          w_nextGrp       = w_lowestLamp;
          w_nextRemaining = WINDOW;
          w_nextState     = S_ANSWER;
        end
      end
      S_ANSWER: begin
        if (wrong || correct || (r_remaining <= 8'd1)) begin
          w_nextState     = S_CLEAR;
          w_nextClrReq    = 1'b1;
          w_nextRemaining = 8'd0;
          w_nextClrCnt    = '0;
          w_scoreInc      = correct && !wrong;
          w_nextTimeout   = !correct && !wrong;
        end else begin
          w_nextRemaining = r_remaining - 8'd1;
        end
      end
      S_CLEAR: begin
        if (r_clrCnt == CLR_LAST) begin
          w_nextState  = S_WAIT_DARK;
          w_nextClrReq = 1'b0;
          w_nextClrCnt = '0;
        end else begin
          w_nextClrCnt = r_clrCnt + 1'b1;
        end
      end
      S_WAIT_DARK: begin
        w_nextClrReq = 1'b0;
        if (lamp == 3'b000) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Registered copies of every round-related output plus the clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp       <= 2'd0;
      r_remaining <= 8'd0;
      r_clrReq    <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_clrCnt    <= '0;
    end else begin
      r_grp       <= w_nextGrp;
      r_remaining <= w_nextRemaining;
      r_clrReq    <= w_nextClrReq;
      r_timeout   <= w_nextTimeout;
      r_busy      <= (w_nextState != S_IDLE);
      r_clrCnt    <= w_nextClrCnt;
    end
  end

  // Saturating scores; a new-game clear takes precedence over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score0 <= '0;
      r_score1 <= '0;
      r_score2 <= '0;
    end else if (score_clr) begin
      r_score0 <= '0;
      r_score1 <= '0;
      r_score2 <= '0;
    end else if (w_scoreInc) begin
      case (r_grp)
        2'd0: if (r_score0 != '1) r_score0 <= r_score0 + 1'b1;
        2'd1: if (r_score1 != '1) r_score1 <= r_score1 + 1'b1;
        default: if (r_score2 != '1) r_score2 <= r_score2 + 1'b1;
      endcase
    end
  end

  assign clr_req   = r_clrReq;
  assign busy      = r_busy;
  assign grp       = r_grp;
  assign remaining = r_remaining;
  assign timeout   = r_timeout;
  assign score0    = r_score0;
  assign score1    = r_score1;
  assign score2    = r_score2;

endmodule
